conv_maxpool2x2: RTL



---
 rtl/conv_maxpool2x2.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/conv_maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool for the conv engine output.
// Keeps one horizontal register and a half-width line buffer; no frame storage.
module conv_maxpool2x2 #(
    parameter int DW   = 20,
    parameter int MAXW = 64,
    parameter int AW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    out_w,
    input  logic [7:0]    out_h,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [6:0]    out_row,
    output logic [6:0]    out_col,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [8:0] W_LIMIT = 9'(2 * MAXW);

    function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t          state_q, state_d;
    logic [7:0]      w_q, w_d;
    logic [7:0]      h_q, h_d;
    logic [7:0]      col_q, col_d;
    logic [7:0]      row_q, row_d;
    logic [DW-1:0]   h_reg_q, h_reg_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [6:0]      out_row_q, out_row_d;
    logic [6:0]      out_col_q, out_col_d;
    logic            cfg_err_q, cfg_err_d;

    logic [DW-1:0]   lbuf_q [MAXW];
    logic [AW-1:0]   lb_addr;
    logic            lb_we;
    logic [DW-1:0]   pair_max;
    logic            size_ok;
    logic            last_col;
    logic            last_row;
    logic            drop;

    assign lb_addr  = col_q[AW:1];
    assign pair_max = max2(h_reg_q, in_data);
    assign size_ok  = (out_w >= 8'd2) && ({1'b0, out_w} <= W_LIMIT) && (out_h >= 8'd2);
    assign last_col = (col_q == w_q - 8'd1);
    assign last_row = (row_q == h_q - 8'd1);
    // Trailing odd column / odd row has no partner to pool with.
    assign drop     = (last_col && !col_q[0]) || (last_row && !row_q[0]);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        col_d       = col_q;
        row_d       = row_q;
        h_reg_d     = h_reg_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        cfg_err_d   = 1'b0;
        lb_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        w_d     = out_w;
                        h_d     = out_h;
                        col_d   = 8'd0;
                        row_d   = 8'd0;
                        state_d = S_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    if (!drop) begin
                        case ({row_q[0], col_q[0]})
                            2'b00, 2'b10: h_reg_d = in_data;
                            2'b01:        lb_we   = 1'b1;
                            2'b11: begin
                                out_valid_d = 1'b1;
                                out_data_d  = max2(lbuf_q[lb_addr], pair_max);
                                out_row_d   = row_q[7:1];
                                out_col_d   = col_q[7:1];
                            end
                        endcase
                    end
                    if (last_col) begin
                        col_d = 8'd0;
                        row_d = row_q + 8'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                    if (last_col && last_row) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            w_q         <= 8'd0;
            h_q         <= 8'd0;
            col_q       <= 8'd0;
            row_q       <= 8'd0;
            h_reg_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= 7'd0;
            out_col_q   <= 7'd0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            col_q       <= col_d;
            row_q       <= row_d;
            h_reg_q     <= h_reg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // NOTE: the line buffer has no reset; each entry is written on an even row before any odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lbuf_q[lb_addr] <= pair_max;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);

endmodule
